node_sort_engine: RTL and testbench
===================================

NODE_SORT_ENGINE -- requirements
Module: node_sort_engine

Interface
REQ-001 SHALL have parameter WEIGHT_W, default 27, width of the node weight field, which is the primary sort key.
REQ-002 SHALL have parameter ID_W, default 9, width of the node id field, which is the tie-break key.
REQ-003 SHALL have parameter DEPTH, default 16, maximum number of nodes per batch; legal values are even and at least 4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, ID_W+WEIGHT_W bits: node frame, {id, weight}, weight in the LSBs.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_last (input, 1, marks the final node of a batch).
REQ-008 SHALL have port out_data, output, ID_W+WEIGHT_W bits: sorted node frame.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1, marks the final emitted node).
REQ-010 SHALL have port count, output, $clog2(DEPTH+1) bits: number of nodes loaded in the current batch.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a batch is fully retired.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SORT and DRAIN.
REQ-013 IDLE: in_ready=1; the first accepted beat (in_valid&in_ready) writes slot 0, sets count=1 and enters LOAD; if in_last is high on that same beat, the FSM SHALL go directly to SORT.
REQ-014 LOAD: each accepted beat writes slot[count] and increments count; in_last or count reaching DEPTH SHALL move the FSM to SORT on the next cycle, with in_ready=0 from that cycle on.
REQ-015 At IDLE exit, all unwritten slots SHALL be filled with a sentinel of all-ones weight and all-ones id, so that sentinels sort last.
REQ-016 Ordering SHALL be lexicographic on (weight, id), ascending; an equal frame is not swapped.
REQ-017 SORT SHALL run exactly DEPTH cycles of odd-even transposition:
  - even cycles compare pairs (0,1),(2,3),...
  - odd cycles compare pairs (1,2),(3,4),...
  - each pair places MIN at the lower index.
REQ-018 DRAIN SHALL present slot[0] upward in order, emitting only the first count slots.
  - Data advances only on out_valid&out_ready; out_data is stable while stalled.
  - out_last=1 on the final emitted slot.
REQ-019 After the last output handshake, the block SHALL pulse done for one cycle, clear count and return to IDLE.
REQ-020 in_valid outside IDLE/LOAD SHALL be ignored; out_ready outside DRAIN SHALL be ignored.
REQ-021 Latency from the SORT-entry cycle to the first out_valid SHALL be exactly DEPTH+1 cycles.

Reset
REQ-022 rst_n low SHALL asynchronously force:
  - state=IDLE, count=0;
  - out_valid=0, out_last=0, done=0, out_data=0;
  - in_ready=1 after release;
  - all slots to 0.
REQ-023 Reset mid-batch SHALL discard the batch with no done pulse.

Configuration
REQ-024 With macro SORT_ZERO_SKIP_EN defined, DRAIN SHALL skip slots whose weight is 0.
  - out_last marks the last non-zero node.
  - If all loaded weights are 0, no out_valid is raised and done pulses on the cycle after SORT completes.
REQ-025 Without SORT_ZERO_SKIP_EN, zero-weight nodes SHALL be emitted like any other node.

Structure
REQ-026 Package node_sort_pkg SHALL hold:
  - the default WEIGHT_W and ID_W;
  - the FSM state typedef;
  - the sentinel constant;
  - the frame-field slice helpers.
REQ-027 One sub-module, node_cmp_swap, SHALL do combinational compare-and-swap (lexicographic weight then id, outputs MAX and MIN); DEPTH/2 instances are shared between even and odd phases.

Verification
REQ-028 Load weights 5,3,9,1 (ids 0-3) with in_last on beat 4 and DEPTH=16 -> outputs (1,id3),(3,id1),(5,id0),(9,id2), out_last on the 4th, then a done pulse.
REQ-029 Load (7,id4) then (7,id2) -> output order (7,id2),(7,id4).
REQ-030 Load 16 nodes without in_last -> in_ready drops after beat 16, the SORT lasts exactly 16 cycles, and 16 sorted outputs follow.
REQ-031 Hold out_ready low for 5 cycles mid-DRAIN -> out_data/out_valid stable, with no loss or duplication.
REQ-032 SORT_ZERO_SKIP_EN build, load weights 0,4,0,2 -> outputs 2 then 4 with out_last; all-zero batch -> no out_valid, one done pulse.
REQ-033 Assert rst_n low during SORT -> outputs at reset values; the next batch sorts correctly.

Source files
------------

// File: rtl/node_sort_pkg.sv
// Shared definitions for node_sort_engine: default field widths, FSM states,
// the sentinel frame and frame field helpers (frames are {id, weight}).
package node_sort_pkg;

  localparam int WEIGHT_W_DEF = 27;
  localparam int ID_W_DEF     = 9;
  localparam int FRAME_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SORT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // All-ones weight and id: compares above every real node.
  localparam logic [FRAME_MAX_W-1:0] SENTINEL = '1;

  // Helpers take a zero-extended frame so they work for any parameterisation.
  function automatic logic [FRAME_MAX_W-1:0] frame_weight(
    input logic [FRAME_MAX_W-1:0] f,
    input int                     ww
  );
    return f & ~(SENTINEL << ww);
  endfunction

  function automatic logic [FRAME_MAX_W-1:0] frame_id(
    input logic [FRAME_MAX_W-1:0] f,
    input int                     ww,
    input int                     iw
  );
    return (f >> ww) & ~(SENTINEL << iw);
  endfunction

endpackage

// File: rtl/node_cmp_swap.sv
// Combinational compare-and-swap on {id, weight} frames: weight is the primary
// key, id breaks ties; equal frames pass through unswapped.
module node_cmp_swap
  import node_sort_pkg::*;
#(
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int ID_W     = ID_W_DEF
) (
  input  logic [ID_W+WEIGHT_W-1:0] i_a,
  input  logic [ID_W+WEIGHT_W-1:0] i_b,
  output logic [ID_W+WEIGHT_W-1:0] o_min,
  output logic [ID_W+WEIGHT_W-1:0] o_max
);

  logic [FRAME_MAX_W-1:0] w_a_wt, w_b_wt, w_a_id, w_b_id;
  logic                   w_b_lt;

  assign w_a_wt = frame_weight(FRAME_MAX_W'(i_a), WEIGHT_W);
  assign w_b_wt = frame_weight(FRAME_MAX_W'(i_b), WEIGHT_W);
  assign w_a_id = frame_id(FRAME_MAX_W'(i_a), WEIGHT_W, ID_W);
  assign w_b_id = frame_id(FRAME_MAX_W'(i_b), WEIGHT_W, ID_W);

  assign w_b_lt = (w_b_wt < w_a_wt) || ((w_b_wt == w_a_wt) && (w_b_id < w_a_id));
  assign o_min  = w_b_lt ? i_b : i_a;
  assign o_max  = w_b_lt ? i_a : i_b;

endmodule

// File: rtl/node_sort_engine.sv
// Batch sorter: load up to DEPTH {id, weight} frames, odd-even transposition sort
// for DEPTH cycles, then stream them out ascending. SORT_ZERO_SKIP_EN drops weight-0 nodes.
module node_sort_engine
  import node_sort_pkg::*;
#(
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int ID_W     = ID_W_DEF,
  parameter int DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ID_W+WEIGHT_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  output logic [ID_W+WEIGHT_W-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output state_e                     dbg_state
);

  localparam int FW   = ID_W + WEIGHT_W;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(DEPTH);
  localparam int HALF = DEPTH / 2;
  localparam logic [CW-1:0] LAST_SLOT  = CW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_PHASE = IW'(DEPTH - 1);
  localparam logic [FW-1:0] SENT       = SENTINEL[FW-1:0];

  // Handshakes: a beat transfers on a rising clk edge where valid && ready.
  // out_data/out_last only change on such a transfer or while out_valid is low.
  state_e        r_state, w_state_nxt;
  logic [FW-1:0] r_slot     [DEPTH];
  logic [FW-1:0] w_slot_nxt [DEPTH];
  logic [FW-1:0] w_cmp_a [HALF];
  logic [FW-1:0] w_cmp_b [HALF];
  logic [FW-1:0] w_min   [HALF];
  logic [FW-1:0] w_max   [HALF];
  logic [CW-1:0] r_count, r_rd, w_skip;
  logic [IW-1:0] r_phase;
  logic [FW-1:0] r_out_data;
  logic          r_out_valid, r_out_last, r_done;
  logic          w_in_acc, w_take, w_all_zero;

  assign in_ready  = (r_state == IDLE) || (r_state == LOAD);
  assign w_in_acc  = in_valid && in_ready;
  assign w_take    = (r_state == DRAIN) && r_out_valid && out_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign count     = r_count;
  assign done      = r_done;
  assign dbg_state = r_state;

`ifdef SORT_ZERO_SKIP_EN
  // Zero weights sort to the front, so skipping them is just a later start index.
  logic [CW-1:0] r_zero_cnt;
  logic          w_in_zero;
  assign w_in_zero = (frame_weight(FRAME_MAX_W'(in_data), WEIGHT_W) == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_zero_cnt <= '0;
    else if ((r_state == IDLE) && w_in_acc) r_zero_cnt <= CW'(w_in_zero);
    else if ((r_state == LOAD) && w_in_acc) r_zero_cnt <= r_zero_cnt + CW'(w_in_zero);
  end
  assign w_skip     = r_zero_cnt;
  assign w_all_zero = (r_zero_cnt == r_count);
`else
  assign w_skip     = '0;
  assign w_all_zero = 1'b0;
`endif

  // Instance k serves pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd ones.
  for (genvar k = 0; k < HALF; k++) begin : g_cmp
    if (k < HALF - 1) begin : g_mid
      assign w_cmp_a[k] = r_phase[0] ? r_slot[2*k+1] : r_slot[2*k];
      assign w_cmp_b[k] = r_phase[0] ? r_slot[2*k+2] : r_slot[2*k+1];
    end else begin : g_end
      assign w_cmp_a[k] = r_slot[2*k];
      assign w_cmp_b[k] = r_slot[2*k+1];
    end
    node_cmp_swap #(.WEIGHT_W(WEIGHT_W), .ID_W(ID_W)) u_cmp_swap (
      .i_a   (w_cmp_a[k]),
      .i_b   (w_cmp_b[k]),
      .o_min (w_min[k]),
      .o_max (w_max[k])
    );
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_nxt
    if (i == 0) begin : g_first
      assign w_slot_nxt[i] = r_phase[0] ? r_slot[i] : w_min[0];
    end else if (i == DEPTH - 1) begin : g_last
      assign w_slot_nxt[i] = r_phase[0] ? r_slot[i] : w_max[HALF-1];
    end else if (i % 2 == 1) begin : g_odd
      assign w_slot_nxt[i] = r_phase[0] ? w_min[i/2] : w_max[i/2];
    end else begin : g_even
      assign w_slot_nxt[i] = r_phase[0] ? w_max[i/2-1] : w_min[i/2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_in_acc) w_state_nxt = in_last ? SORT : LOAD;
      LOAD:    if (w_in_acc && (in_last || (r_count == LAST_SLOT))) w_state_nxt = SORT;
      SORT:    if (r_phase == LAST_PHASE) w_state_nxt = w_all_zero ? IDLE : DRAIN;
      DRAIN:   if (w_take && r_out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_count     <= '0;
      r_rd        <= '0;
      r_phase     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_phase <= '0;
          if (w_in_acc) begin
            r_slot[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) r_slot[i] <= SENT;
            r_count <= CW'(1);
          end
        end
        LOAD: begin
          if (w_in_acc) begin
            r_slot[r_count[IW-1:0]] <= in_data;
            r_count <= r_count + CW'(1);
          end
        end
        SORT: begin
          for (int i = 0; i < DEPTH; i++) r_slot[i] <= w_slot_nxt[i];
          r_phase <= r_phase + IW'(1);
          r_rd    <= w_skip;
          if ((r_phase == LAST_PHASE) && w_all_zero) begin
            r_done  <= 1'b1;
            r_count <= '0;
          end
        end
        DRAIN: begin
          if (!r_out_valid || w_take) begin
            if (r_rd < r_count) begin
              r_out_data  <= r_slot[r_rd[IW-1:0]];
              r_out_valid <= 1'b1;
              r_out_last  <= (r_rd == r_count - CW'(1));
              r_rd        <= r_rd + CW'(1);
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
          if (w_take && r_out_last) begin
            r_done  <= 1'b1;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_sort_engine.sv
// Scoreboard bench for node_sort_engine: a queue-based insertion-sort model predicts
// each batch; a negedge monitor pops and compares every output handshake.
module tb_node_sort_engine;

  localparam int WW    = 27;
  localparam int IDW   = 9;
  localparam int DEPTH = 16;
  localparam int FW    = WW + IDW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [FW-1:0]          in_data;
  logic                   in_valid, in_ready, in_last;
  logic [FW-1:0]          out_data;
  logic                   out_valid, out_ready, out_last;
  logic [CW-1:0]          count;
  logic                   done;
  node_sort_pkg::state_e  dbg_state;

  node_sort_engine #(.WEIGHT_W(WW), .ID_W(IDW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .count     (count),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [FW-1:0] exp_q[$];
  bit            exp_last_q[$];
  logic [FW-1:0] batch[$];
  int            checks = 0;
  int            failures = 0;
  int            hs_count = 0;
  int            done_seen = 0;
  bit            batch_pending = 0;
  bit            done_prev = 0;
  int            stall_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int unsigned w, input int unsigned id);
    logic [FW-1:0] f;
    f = {IDW'(id), WW'(w)};
    return f;
  endfunction

  // a strictly precedes b in (weight, id) order
  function automatic bit precedes(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [WW-1:0]  aw, bw;
    logic [IDW-1:0] ai, bi;
    aw = a[WW-1:0];  bw = b[WW-1:0];
    ai = a[FW-1:WW]; bi = b[FW-1:WW];
    if (aw != bw) return aw < bw;
    return ai < bi;
  endfunction

  task automatic add(input int unsigned w, input int unsigned id);
    batch.push_back(mk(w, id));
  endtask

  task automatic expect_batch();
    logic [FW-1:0] s[$];
    int p;
    foreach (batch[i]) begin
`ifdef SORT_ZERO_SKIP_EN
      if (batch[i][WW-1:0] == '0) continue;
`endif
      p = s.size();
      for (int j = 0; j < s.size(); j++) begin
        if (precedes(batch[i], s[j])) begin
          p = j;
          break;
        end
      end
      s.insert(p, batch[i]);
    end
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      exp_last_q.push_back(i == s.size() - 1);
    end
  endtask

  // ---------------- monitor ----------------
  logic [FW-1:0] mon_e;
  bit            mon_l;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=%0h required=no_output", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = exp_last_q.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e));
        check("out_last", 64'(out_last), 64'(mon_l));
      end
    end
    if (rst_n && done) begin
      check("done_one_cycle", 64'(done_prev), 64'(0));
      check("done_expected", 64'(batch_pending), 64'(1));
      check("done_all_retired", 64'(exp_q.size()), 64'(0));
      batch_pending = 0;
      done_seen++;
    end
    done_prev = done;
  end

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cycles > 0) begin
        out_ready = 1'b0;
        stall_cycles--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_batch(input bit use_last, output bit acc_ok);
    int t;
    bit ok;
    acc_ok = 1'b1;
    for (int i = 0; i < batch.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_data  = batch[i];
      in_valid = 1'b1;
      in_last  = use_last && (i == batch.size() - 1);
      ok = 1'b0;
      t  = 0;
      while (!ok) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        t++;
        if (!ok && t > 50) begin
          checks++;
          failures++;
          $display("FAIL in_ready_timeout actual=0 required=1");
          acc_ok = 1'b0;
          break;
        end
      end
      if (!acc_ok) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_sort_timing(input int n);
    int lat, sort_cyc;
    lat = 0;
    sort_cyc = 0;
    @(negedge clk);
    check("in_ready_low_in_sort", 64'(in_ready), 64'(0));
    check("count_loaded", 64'(count), 64'(n));
    while (!out_valid && lat < 200) begin
      if (dbg_state == node_sort_pkg::SORT) sort_cyc++;
      lat++;
      @(negedge clk);
    end
    check("first_out_latency", 64'(lat), 64'(DEPTH + 1));
    check("sort_cycles", 64'(sort_cyc), 64'(DEPTH));
  endtask

  task automatic check_zero_timing(input int n);
    int lat;
    bit saw;
    lat = 0;
    saw = 0;
    @(negedge clk);
    check("count_loaded", 64'(count), 64'(n));
    while (!done && lat < 200) begin
      if (out_valid) saw = 1;
      lat++;
      @(negedge clk);
    end
    check("zero_batch_done_latency", 64'(lat), 64'(DEPTH));
    check("zero_batch_no_valid", 64'(saw), 64'(0));
  endtask

  task automatic stall_check(input int hs_base);
    int t;
    logic [FW-1:0] snap;
    t = 0;
    while (!((hs_count - hs_base) >= 3 && out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    stall_cycles = 5;
    @(posedge clk);
    @(negedge clk);
    snap = out_data;
    check("stall_valid", 64'(out_valid), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid_held", 64'(out_valid), 64'(1));
      check("stall_data_held", 64'(out_data), 64'(snap));
    end
  endtask

  task automatic wait_done(input int seen0);
    int t;
    t = 0;
    while (done_seen == seen0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (done_seen == seen0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done_pulse");
      exp_q.delete();
      exp_last_q.delete();
      batch_pending = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input bit use_last, input bit use_model, input bit do_stall);
    bit acc_ok;
    int n_exp, hs_base, seen0;
    if (use_model) expect_batch();
    batch_pending = 1;
    n_exp   = exp_q.size();
    hs_base = hs_count;
    seen0   = done_seen;
    send_batch(use_last, acc_ok);
    if (acc_ok) begin
      if (n_exp > 0) check_sort_timing(batch.size());
      else           check_zero_timing(batch.size());
      if (do_stall) stall_check(hs_base);
    end
    wait_done(seen0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // 5,3,9,1 with ids 0..3
    batch.delete();
    add(5, 0); add(3, 1); add(9, 2); add(1, 3);
    exp_q = '{mk(1, 3), mk(3, 1), mk(5, 0), mk(9, 2)};
    exp_last_q = '{0, 0, 0, 1};
    run_batch(1, 0, 0);

    // equal weights resolved by id
    batch.delete();
    add(7, 4); add(7, 2);
    exp_q = '{mk(7, 2), mk(7, 4)};
    exp_last_q = '{0, 1};
    run_batch(1, 0, 0);

    // zero weights mixed in
    batch.delete();
    add(0, 0); add(4, 1); add(0, 2); add(2, 3);
`ifdef SORT_ZERO_SKIP_EN
    exp_q = '{mk(2, 3), mk(4, 1)};
    exp_last_q = '{0, 1};
`else
    exp_q = '{mk(0, 0), mk(0, 2), mk(2, 3), mk(4, 1)};
    exp_last_q = '{0, 0, 0, 1};
`endif
    run_batch(1, 0, 0);

    // all-zero batch
    batch.delete();
    add(0, 5); add(0, 1); add(0, 3);
    run_batch(1, 1, 0);

    // full batch, no in_last, with a mid-drain stall
    batch.delete();
    for (int i = 0; i < DEPTH; i++) add($urandom_range(1, 40), $urandom_range(0, 511));
    run_batch(0, 1, 1);

    // single node
    batch.delete();
    add($urandom_range(1, 1000), $urandom_range(0, 511));
    run_batch(1, 1, 0);

    // randomized batches
    for (int b = 0; b < 12; b++) begin
      int n;
      bit ul;
      n  = $urandom_range(1, DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      batch.delete();
      for (int i = 0; i < n; i++)
        add(($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 7), $urandom_range(0, 511));
      run_batch(ul, 1, 0);
    end

    // reset in the middle of SORT
    begin
      bit acc_ok;
      batch.delete();
      for (int i = 0; i < 6; i++) add($urandom_range(1, 50), i);
      send_batch(1, acc_ok);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_out_last", 64'(out_last), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_out_data", 64'(out_data), 64'(0));
      check("midrst_count", 64'(count), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      check("midrst_state", 64'(dbg_state), 64'(node_sort_pkg::IDLE));
      exp_q.delete();
      exp_last_q.delete();
      batch_pending = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_no_done", 64'(done_prev), 64'(0));
      @(posedge clk);
      #1;
    end

    batch.delete();
    for (int i = 0; i < 9; i++) add($urandom_range(0, 20), $urandom_range(0, 511));
    run_batch(1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
